// File: rtl/audio_sample_scheduler_if.sv
// iomem bus slice between the picosoc CPU and the audio sample scheduler.
// Latency: none here; the slave answers one cycle after a selected request.
// Backpressure: none, the slave never inserts wait states.
interface audio_sample_scheduler_if;
  logic        sel;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/audio_sample_scheduler.sv
// Sample FIFO plus programmable divider feeding the 12-bit PDM DAC; optional low-water irq under AUDIO_SCHED_IRQ_EN.
// Latency: bus ack 1 cycle; first sample DIV+1 cycles after enable, then one every DIV+1 cycles.
// Backpressure: none; pushes into a full FIFO are dropped and flagged as overflow.
module audio_sample_scheduler #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  audio_sample_scheduler_if.slave  bus,
  output logic [11:0]              sample_out,
  output logic                     irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, cnt_q;
  logic [PW-1:0]      wptr_q, rptr_q, level;
  logic [11:0]        mem [DEPTH];
  logic               underrun_q, overflow_q;
  logic [3:0]         thresh_rd;
  logic [31:0]        rd_mux;

  logic access, wr_acc, wr_data, wr_div, wr_ctrl, wr_stat;
  logic empty, full, tick, flush, push, pop;
  logic [1:0] reg_idx;
  logic unused_bits;

  assign reg_idx = bus.iomem_addr[3:2];
  assign access  = bus.iomem_valid && bus.sel && !bus.iomem_ready;
  // Any nonzero strobe is treated as a whole-register write.
  assign wr_acc  = access && (bus.iomem_wstrb != 4'b0000);
  assign wr_data = wr_acc && (reg_idx == 2'd0);
  assign wr_div  = wr_acc && (reg_idx == 2'd1);
  assign wr_ctrl = wr_acc && (reg_idx == 2'd2);
  assign wr_stat = wr_acc && (reg_idx == 2'd3);

  assign level = wptr_q - rptr_q;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));
  assign flush = wr_ctrl && bus.iomem_wdata[1];
  assign tick  = (state_q == RUN) && (cnt_q == div_q);
  // Fullness uses the pre-pop level; flush overrides both sides.
  assign push  = wr_data && !full && !flush;
  assign pop   = tick && !empty && !flush;

  assign unused_bits = ^{bus.iomem_addr[31:4], bus.iomem_addr[1:0], bus.iomem_wdata};

  // Register read mux; reserved bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      2'd1: rd_mux[DIV_W-1:0] = div_q;
      2'd2: begin
        rd_mux[0]    = (state_q == RUN);
        rd_mux[11:8] = thresh_rd;
      end
      2'd3: begin
        rd_mux[6:0] = 7'(level);
        rd_mux[8]   = empty;
        rd_mux[9]   = full;
        rd_mux[10]  = underrun_q;
        rd_mux[11]  = overflow_q;
      end
      default: rd_mux = '0;
    endcase
  end

  // One-cycle bus acknowledge; read data is captured only on an accepted access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
    end else begin
      bus.iomem_ready <= access;
      if (access) bus.iomem_rdata <= rd_mux;
    end
  end

  // Scheduler state follows the enable bit written through CTRL.
  always_comb begin
    state_d = state_q;
    if (wr_ctrl) state_d = bus.iomem_wdata[0] ? RUN : IDLE;
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Divider register and period counter; counter parks at 0 while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_div) div_q <= bus.iomem_wdata[DIV_W-1:0];
      if (state_q == IDLE || wr_div || tick) cnt_q <= '0;
      else                                   cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  // FIFO pointers, one bit wider than the address so full and empty differ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= bus.iomem_wdata[11:0];
  end

  // DAC sample register; holds across idle, underrun and flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  sample_out <= 12'h800;
    else if (pop) sample_out <= mem[rptr_q[AW-1:0]];
  end

  // Sticky error flags; a new event in the same cycle beats a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (tick && empty)                         underrun_q <= 1'b1;
      else if (wr_stat && bus.iomem_wdata[10])   underrun_q <= 1'b0;
      if (wr_data && full)                       overflow_q <= 1'b1;
      else if (wr_stat && bus.iomem_wdata[11])   overflow_q <= 1'b0;
    end
  end

`ifdef AUDIO_SCHED_IRQ_EN
  logic [3:0] thresh_q;

  assign thresh_rd = thresh_q;

  // Low-water threshold and registered level-sensitive interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thresh_q <= 4'h0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) thresh_q <= bus.iomem_wdata[11:8];
      irq <= (state_q == RUN) && (int'(level) <= int'(thresh_q));
    end
  end
`else
  assign thresh_rd = 4'h0;
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Self-checking bench for audio_sample_scheduler: expected values come from a queue model and period arithmetic.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_sample_scheduler;
`ifdef AUDIO_SCHED_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic        clk;
  logic        resetn;
  logic [11:0] sample_out;
  logic        irq;
  int          n_checks;
  int          n_fail;

  audio_sample_scheduler_if bus ();

  audio_sample_scheduler #(.DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .sample_out (sample_out),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_access(input logic [1:0] idx, input logic [3:0] strb,
                            input logic [31:0] wd, output logic [31:0] rd);
    int waited;
    bus.sel         = 1'b1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = {8'h04, 22'h0, idx, 2'b00};
    bus.iomem_wstrb = strb;
    bus.iomem_wdata = wd;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!bus.iomem_ready && waited < 4);
    n_checks++;
    if (bus.iomem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_ready_timeout: ready=%b required 1", bus.iomem_ready);
    end
    rd = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
    bus.sel         = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_access(idx, 4'hF, wd, dummy);
  endtask

  task automatic bus_read(input logic [1:0] idx, output logic [31:0] rd);
    bus_access(idx, 4'h0, 32'h0, rd);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    n_checks++;
    if (sample_out !== 12'h800) begin n_fail++; $display("FAIL reset_sample: got %h expected 800", sample_out); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++;
    if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: ready=%b rdata=%h expected 0/0", bus.iomem_ready, bus.iomem_rdata);
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h100) begin n_fail++; $display("FAIL reset_status: got %h expected 00000100", rd); end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_div: got %h expected 0", rd); end
  endtask

  task automatic test_playback();
    logic [31:0] rd;
    do_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h123);
    bus_write(2'd0, 32'h456);
    bus_write(2'd2, 32'h1);
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== 12'h800) begin n_fail++; $display("FAIL play_early: got %h expected 800", sample_out); end
    @(posedge clk); #1;
    n_checks++;
    if (sample_out !== 12'h123) begin n_fail++; $display("FAIL play_first: got %h expected 123", sample_out); end
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== 12'h456) begin n_fail++; $display("FAIL play_second: got %h expected 456", sample_out); end
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== 12'h456) begin n_fail++; $display("FAIL play_hold: got %h expected 456", sample_out); end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h500) begin n_fail++; $display("FAIL play_underrun: got %h expected 00000500", rd); end
  endtask

  task automatic test_random_playback();
    logic [31:0] rd;
    logic [11:0] q[$];
    logic [11:0] v, exp_s;
    int div, n, ticks;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      q.delete();
      div = $urandom_range(0, 4);
      n   = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        v = 12'($urandom_range(0, 4095));
        q.push_back(v);
        bus_write(2'd0, {20'($urandom()), v});
      end
      bus_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'(n)) begin n_fail++; $display("FAIL rnd_level: got %h expected %h", rd, n); end
      bus_write(2'd1, 32'(div));
      bus_write(2'd2, 32'h1);
      for (int t = 1; t <= (n + 1) * (div + 1); t++) begin
        if (t > 1) begin @(posedge clk); #1; end
        ticks = t / (div + 1);
        exp_s = (ticks == 0) ? 12'h800 : q[((ticks > n) ? n : ticks) - 1];
        n_checks++;
        if (sample_out !== exp_s) begin
          n_fail++; $display("FAIL rnd_sample: div=%0d t=%0d got %h expected %h", div, t, sample_out, exp_s);
        end
      end
      bus_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h500) begin n_fail++; $display("FAIL rnd_status: got %h expected 00000500", rd); end
      bus_write(2'd2, 32'h0);
      bus_write(2'd3, 32'h400);
      bus_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h100) begin n_fail++; $display("FAIL rnd_clear: got %h expected 00000100", rd); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [11:0] q[$];
    logic [11:0] v, exp_s;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 12'($urandom_range(0, 4095));
      q.push_back(v);
      bus_write(2'd0, {20'h0, v});
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'hA10) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000a10", rd); end
    bus_write(2'd3, 32'h800);
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h210) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00000210", rd); end
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h1);
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_s = q[(k > DEPTH - 1) ? DEPTH - 1 : k];
      n_checks++;
      if (sample_out !== exp_s) begin
        n_fail++; $display("FAIL ovf_drain: k=%0d got %h expected %h", k, sample_out, exp_s);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    do_reset();
    bus_write(2'd1, 32'd20);
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'($urandom_range(0, 4095)));
    bus_write(2'd2, 32'h3);
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h100) begin n_fail++; $display("FAIL flush_status: got %h expected 00000100", rd); end
    bus_write(2'd0, 32'h5A5);
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 00000001", rd); end
    repeat (13) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== 12'h800) begin n_fail++; $display("FAIL flush_hold: got %h expected 800", sample_out); end
    @(posedge clk); #1;
    n_checks++;
    if (sample_out !== 12'h5A5) begin n_fail++; $display("FAIL flush_next: got %h expected 5a5", sample_out); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic exp_irq;
    int lvl;
    do_reset();
    for (int i = 0; i < 4; i++) bus_write(2'd0, 32'($urandom_range(0, 4095)));
    bus_write(2'd2, 32'h201);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      lvl = (4 - (k - 1) > 0) ? 4 - (k - 1) : 0;
      exp_irq = IRQ_EN && (lvl <= 2);
      n_checks++;
      if (irq !== exp_irq) begin n_fail++; $display("FAIL irq_rise: k=%0d got %b expected %b", k, irq, exp_irq); end
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== (IRQ_EN ? 32'h201 : 32'h001)) begin n_fail++; $display("FAIL irq_ctrl: got %h", rd); end
    bus_write(2'd2, 32'h200);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [11:0] q[$];
    logic [11:0] x;
    do_reset();
    bus_write(2'd1, 32'd3);
    for (int i = 0; i < 4; i++) begin
      q.push_back(12'($urandom_range(0, 4095)));
      bus_write(2'd0, {20'h0, q[i]});
    end
    x = 12'($urandom_range(0, 4095));
    bus_write(2'd2, 32'h1);
    repeat (6) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== q[0]) begin n_fail++; $display("FAIL pp_first: got %h expected %h", sample_out, q[0]); end
    bus_write(2'd0, {20'h0, x});
    n_checks++;
    if (sample_out !== q[1]) begin n_fail++; $display("FAIL pp_pop: got %h expected %h", sample_out, q[1]); end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL pp_level: got %h expected 00000003", rd); end
    @(posedge clk); #1;
    n_checks++;
    if (sample_out !== q[2]) begin n_fail++; $display("FAIL pp_third: got %h expected %h", sample_out, q[2]); end
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== q[3]) begin n_fail++; $display("FAIL pp_fourth: got %h expected %h", sample_out, q[3]); end
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== x) begin n_fail++; $display("FAIL pp_pushed: got %h expected %h", sample_out, x); end
  endtask

  task automatic test_reset_midplay();
    logic [31:0] rd;
    logic [11:0] first;
    do_reset();
    first = 12'($urandom_range(0, 2047));
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, {20'h0, first});
    bus_write(2'd0, 32'h0AB);
    bus_write(2'd0, 32'h0CD);
    bus_write(2'd2, 32'hF01);
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (sample_out !== first || irq !== IRQ_EN) begin
      n_fail++; $display("FAIL mid_before: sample=%h irq=%b expected %h/%b", sample_out, irq, first, IRQ_EN);
    end
    bus.sel = 1'b1; bus.iomem_valid = 1'b1; bus.iomem_wstrb = 4'h0;
    bus.iomem_addr = {8'h04, 22'h0, 2'd3, 2'b00};
    @(posedge clk); #1;
    n_checks++;
    if (bus.iomem_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", bus.iomem_ready); end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (sample_out !== 12'h800 || irq !== 1'b0 || bus.iomem_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: sample=%h irq=%b ready=%b expected 800/0/0", sample_out, irq, bus.iomem_ready);
    end
    bus.sel = 1'b0; bus.iomem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h100) begin n_fail++; $display("FAIL mid_status: got %h expected 00000100", rd); end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl: got %h expected 0", rd); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    bus.sel = 1'b0; bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
    bus.iomem_addr = 32'h0; bus.iomem_wdata = 32'h0;
    test_reset();
    test_playback();
    test_random_playback();
    test_overflow();
    test_flush();
    test_irq();
    test_back_to_back();
    test_reset_midplay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
